vend_ctrl: RTL and testbench

Sequencing controller for the soda vending datapath. It accepts nickel, dime and quarter coin pulses into a credit register and decides when the price is met. It then runs a request/acknowledge handshake with the soda dispenser and pays change or refunds one nickel at a time to a coin-hopper handshake. It sits between the coin-slot front end and the dispenser/hopper actuators, so those actuators never see overlapping commands.

---
 rtl/vend_pkg.sv | 31 +++
 rtl/vend_credit.sv | 44 ++++
 rtl/vend_ctrl.sv | 152 +++++++++++++++
 tb/tb_vend_ctrl.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types and constants for the soda vending controller
// Contents: vend_state_t FSM encoding, coin values, the payout step and a
// coin decode helper used by vend_ctrl.
package vend_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_VEND    = 2'd2,
    S_PAYOUT  = 2'd3
  } vend_state_t;

  localparam int CREDIT_W = 6;
  localparam int COUNT_W  = 4;

  localparam logic [CREDIT_W-1:0] NICKEL_C    = 6'd5;
  localparam logic [CREDIT_W-1:0] DIME_C      = 6'd10;
  localparam logic [CREDIT_W-1:0] QUARTER_C   = 6'd25;
  localparam logic [CREDIT_W-1:0] NICKEL_STEP = 6'd5;

  // Value of a single coin; only meaningful when at most one input is high.
  function automatic logic [CREDIT_W-1:0] coin_value(input logic n, input logic d, input logic q);
    logic [CREDIT_W-1:0] v;
    v = '0;
    if (n) v = NICKEL_C;
    if (d) v = DIME_C;
    if (q) v = QUARTER_C;
    return v;
  endfunction

endpackage

// File: rtl/vend_credit.sv
// rtl/vend_credit.sv - credit register and paid-nickel counter
// Ports:
//   clk_i, rst_i      clock, synchronous active-high reset
//   clear             zero the credit register
//   add_en, add_val   add a coin value to credit
//   sub_en, sub_val   subtract from credit (wins over add)
//   cnt_inc, cnt_clr  nickel counter increment / clear (clear wins)
//   credit            current credit in cents
//   count             nickels paid so far in the current payout
module vend_credit
  import vend_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clear,
  input  logic                add_en,
  input  logic [CREDIT_W-1:0] add_val,
  input  logic                sub_en,
  input  logic [CREDIT_W-1:0] sub_val,
  input  logic                cnt_inc,
  input  logic                cnt_clr,
  output logic [CREDIT_W-1:0] credit,
  output logic [COUNT_W-1:0]  count
);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      credit <= '0;
    end else if (sub_en) begin
      credit <= credit - sub_val;
    end else if (add_en) begin
      credit <= credit + add_val;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || cnt_clr) begin
      count <= '0;
    end else if (cnt_inc) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// rtl/vend_ctrl.sv - vending sequencer: coin intake, vend handshake, nickel payout
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   nickle_i, dime_i, quater_i   one-cycle coin samples
//   cancel_i                     refund request (honoured only in COLLECT)
//   vend_ack_i                   dispenser released a soda (used in VEND)
//   coin_rdy_i                   hopper ejects a nickel this cycle (used in PAYOUT)
//   vend_req_o                   dispense request, high throughout VEND
//   nickel_req_o                 eject request, high throughout PAYOUT
//   coin_rej_o                   one-cycle pulse after a rejected coin sample
//   credit_o                     current credit in cents
//   change_o                     nickels paid by the last completed transaction
//   busy_o                       high in VEND or PAYOUT
module vend_ctrl
  import vend_pkg::*;
#(
  parameter int PRICE = 20
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                nickle_i,
  input  logic                dime_i,
  input  logic                quater_i,
  input  logic                cancel_i,
  input  logic                vend_ack_i,
  input  logic                coin_rdy_i,
  output logic                vend_req_o,
  output logic                nickel_req_o,
  output logic                coin_rej_o,
  output logic [CREDIT_W-1:0] credit_o,
  output logic [COUNT_W-1:0]  change_o,
  output logic                busy_o
);

  localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

  vend_state_t         state, state_next;
  logic [CREDIT_W-1:0] credit;
  logic [COUNT_W-1:0]  count;
  logic [COUNT_W-1:0]  change_q, change_val;
  logic                change_load;
  logic                rej_q, rej_next;

  logic                add_en, sub_en, cnt_inc, cnt_clr;
  logic [CREDIT_W-1:0] sub_val, coin_val;
  logic [1:0]          coin_cnt;
  logic                any_coin, one_coin, open, cancel_hon, accept;
  logic [CREDIT_W:0]   sum;

  // Coin decode
  assign coin_cnt   = {1'b0, nickle_i} + {1'b0, dime_i} + {1'b0, quater_i};
  assign any_coin   = (coin_cnt != 2'd0);
  assign one_coin   = (coin_cnt == 2'd1);
  assign coin_val   = coin_value(nickle_i, dime_i, quater_i);
  assign open       = (state == S_IDLE) || (state == S_COLLECT);
  assign cancel_hon = cancel_i && (state == S_COLLECT);
  // A coin arriving with an honoured cancel is returned so the refund
  // amount is the credit the customer saw when pressing cancel.
  assign accept     = one_coin && open && !cancel_hon;
  assign sum        = {1'b0, credit} + {1'b0, coin_val};

  always_comb begin
    state_next  = state;
    add_en      = 1'b0;
    sub_en      = 1'b0;
    sub_val     = NICKEL_STEP;
    cnt_inc     = 1'b0;
    cnt_clr     = 1'b0;
    change_load = 1'b0;
    change_val  = '0;
    rej_next    = any_coin && !accept;

    case (state)
      S_IDLE, S_COLLECT: begin
        if (cancel_hon) begin
          state_next = S_PAYOUT;
        end else if (accept) begin
          add_en     = 1'b1;
          state_next = (sum >= {1'b0, PRICE_C}) ? S_VEND : S_COLLECT;
        end
      end
      S_VEND: begin
        if (vend_ack_i) begin
          sub_en  = 1'b1;
          sub_val = PRICE_C;
          if (credit == PRICE_C) begin
            state_next  = S_IDLE;
            change_load = 1'b1;
            change_val  = '0;
          end else begin
            state_next = S_PAYOUT;
          end
        end
      end
      S_PAYOUT: begin
        if (coin_rdy_i) begin
          sub_en  = 1'b1;
          sub_val = NICKEL_STEP;
          cnt_inc = 1'b1;
          if (credit == NICKEL_STEP) begin
            // Last nickel: publish the total including this one and rearm
            // the counter for the next transaction.
            state_next  = S_IDLE;
            change_load = 1'b1;
            change_val  = count + 4'd1;
            cnt_clr     = 1'b1;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      rej_q    <= 1'b0;
      change_q <= '0;
    end else begin
      state <= state_next;
      rej_q <= rej_next;
      if (change_load) begin
        change_q <= change_val;
      end
    end
  end

  vend_credit u_credit (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (1'b0),
    .add_en  (add_en),
    .add_val (coin_val),
    .sub_en  (sub_en),
    .sub_val (sub_val),
    .cnt_inc (cnt_inc),
    .cnt_clr (cnt_clr),
    .credit  (credit),
    .count   (count)
  );

  assign vend_req_o   = (state == S_VEND);
  assign nickel_req_o = (state == S_PAYOUT);
  assign busy_o       = (state == S_VEND) || (state == S_PAYOUT);
  assign coin_rej_o   = rej_q;
  assign credit_o     = credit;
  assign change_o     = change_q;

  a_payout_credit: assert property (@(posedge clk_i) disable iff (rst_i)
    (state == S_PAYOUT) |-> (credit >= NICKEL_STEP));

endmodule

// File: tb/tb_vend_ctrl.sv
// tb/tb_vend_ctrl.sv - table-driven scoreboard bench for vend_ctrl (PRICE = 20)
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       nickel = 1'b0, dime = 1'b0, quarter = 1'b0, cancel = 1'b0;
  logic       vend_ack = 1'b0, coin_rdy = 1'b0;
  logic       vend_req, nickel_req, coin_rej, busy;
  logic [5:0] credit;
  logic [3:0] change;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vend_ctrl #(.PRICE(20)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .nickle_i     (nickel),
    .dime_i       (dime),
    .quater_i     (quarter),
    .cancel_i     (cancel),
    .vend_ack_i   (vend_ack),
    .coin_rdy_i   (coin_rdy),
    .vend_req_o   (vend_req),
    .nickel_req_o (nickel_req),
    .coin_rej_o   (coin_rej),
    .credit_o     (credit),
    .change_o     (change),
    .busy_o       (busy)
  );

  typedef struct {
    string      name;
    logic [6:0] in;      // {rst, nickel, dime, quarter, cancel, ack, rdy}
    logic [5:0] credit;
    logic [3:0] change;
    logic [3:0] flags;   // {vend_req, nickel_req, coin_rej, busy}
  } vec_t;

  typedef struct {
    string      name;
    logic [5:0] credit;
    logic [3:0] change;
    logic [3:0] flags;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  task automatic add(input string nm, input logic [6:0] in, input logic [5:0] cr,
                     input logic [3:0] ch, input logic [3:0] fl);
    vec_t v;
    v.name = nm; v.in = in; v.credit = cr; v.change = ch; v.flags = fl;
    tbl.push_back(v);
  endtask

  task automatic check(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then
  // sample 1 time unit after the edge and compare against the queue head.
  task automatic step(input vec_t v);
    exp_t e;
    exp_t got;
    {rst, nickel, dime, quarter, cancel, vend_ack, coin_rdy} = v.in;
    e.name = v.name; e.credit = v.credit; e.change = v.change; e.flags = v.flags;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL %s scoreboard empty", v.name);
    end else begin
      got = sb.pop_front();
      check({got.name, ".credit"},     int'(credit),     int'(got.credit));
      check({got.name, ".change"},     int'(change),     int'(got.change));
      check({got.name, ".vend_req"},   int'(vend_req),   int'(got.flags[3]));
      check({got.name, ".nickel_req"}, int'(nickel_req), int'(got.flags[2]));
      check({got.name, ".coin_rej"},   int'(coin_rej),   int'(got.flags[1]));
      check({got.name, ".busy"},       int'(busy),       int'(got.flags[0]));
    end
  endtask

  task automatic hand(input string nm, input logic [6:0] in, input logic [5:0] cr,
                      input logic [3:0] ch, input logic [3:0] fl);
    vec_t v;
    v.name = nm; v.in = in; v.credit = cr; v.change = ch; v.flags = fl;
    step(v);
  endtask

  // Input bit patterns {rst,n,d,q,cancel,ack,rdy}
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_RST  = 7'b1000000;
  localparam logic [6:0] I_N    = 7'b0100000;
  localparam logic [6:0] I_D    = 7'b0010000;
  localparam logic [6:0] I_Q    = 7'b0001000;
  localparam logic [6:0] I_C    = 7'b0000100;
  localparam logic [6:0] I_ACK  = 7'b0000010;
  localparam logic [6:0] I_RDY  = 7'b0000001;
  // Output flags {vend_req, nickel_req, coin_rej, busy}
  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_VEND = 4'b1001;
  localparam logic [3:0] F_PAY  = 4'b0101;
  localparam logic [3:0] F_REJ  = 4'b0010;

  initial begin
    // Main table
    add("reset",         I_RST,         6'd0,  4'd0, F_IDLE);
    add("t1_dime1",      I_D,           6'd10, 4'd0, F_IDLE);
    add("t1_dime2",      I_D,           6'd20, 4'd0, F_VEND);
    add("t1_wait_ack",   I_NONE,        6'd20, 4'd0, F_VEND);
    add("t1_ack",        I_ACK,         6'd0,  4'd0, F_IDLE);
    add("t2_quarter",    I_Q,           6'd25, 4'd0, F_VEND);
    add("t2_ack",        I_ACK,         6'd5,  4'd0, F_PAY);
    add("t2_nickel",     I_RDY,         6'd0,  4'd1, F_IDLE);
    add("t4_dime",       I_D,           6'd10, 4'd1, F_IDLE);
    add("t4_ack_ignored",I_ACK,         6'd10, 4'd1, F_IDLE);
    add("t4_cancel",     I_C,           6'd10, 4'd1, F_PAY);
    add("t4_pay1",       I_RDY,         6'd5,  4'd1, F_PAY);
    add("t4_pay2_ack",   I_RDY | I_ACK, 6'd0,  4'd2, F_IDLE);
    add("rej_nd_idle",   I_N | I_D,     6'd0,  4'd2, F_REJ);
    add("rej_clear",     I_NONE,        6'd0,  4'd2, F_IDLE);
    add("idle_ignores",  I_ACK | I_RDY | I_C, 6'd0, 4'd2, F_IDLE);
    add("rv_dime1",      I_D,           6'd10, 4'd2, F_IDLE);
    add("rv_dime2",      I_D,           6'd20, 4'd2, F_VEND);
    add("rej_dime_vend", I_D,           6'd20, 4'd2, F_VEND | F_REJ);
    add("vend_cancel",   I_C,           6'd20, 4'd2, F_VEND);
    add("rv_ack",        I_ACK,         6'd0,  4'd0, F_IDLE);
    add("rc_nickel",     I_N,           6'd5,  4'd0, F_IDLE);
    add("rej_q_cancel",  I_Q | I_C,     6'd5,  4'd0, F_PAY | F_REJ);
    add("rc_pay",        I_RDY,         6'd0,  4'd1, F_IDLE);

    foreach (tbl[i]) step(tbl[i]);

    // Stall between nickels: credit holds at 5 and nickel_req stays high
    hand("t3_nickel",    I_N,    6'd5,  4'd1, F_IDLE);
    hand("t3_quarter",   I_Q,    6'd30, 4'd1, F_VEND);
    hand("t3_ack",       I_ACK,  6'd10, 4'd1, F_PAY);
    hand("t3_pay1",      I_RDY,  6'd5,  4'd1, F_PAY);
    hand("t3_stall1",    I_NONE, 6'd5,  4'd1, F_PAY);
    hand("t3_stall2",    I_NONE, 6'd5,  4'd1, F_PAY);
    hand("t3_pay2",      I_RDY,  6'd0,  4'd2, F_IDLE);

    // Reset in mid-PAYOUT beats a coin and a ready hopper
    hand("r_nickel",     I_N,    6'd5,  4'd2, F_IDLE);
    hand("r_quarter",    I_Q,    6'd30, 4'd2, F_VEND);
    hand("r_ack",        I_ACK,  6'd10, 4'd2, F_PAY);
    hand("r_stall",      I_NONE, 6'd10, 4'd2, F_PAY);
    hand("r_reset",      I_RST | I_D | I_RDY, 6'd0, 4'd0, F_IDLE);
    hand("r_new_dime",   I_D,    6'd10, 4'd0, F_IDLE);

    // Reset in mid-VEND with an acknowledge present
    hand("rv2_dime",     I_D,    6'd20, 4'd0, F_VEND);
    hand("rv2_reset",    I_RST | I_ACK, 6'd0, 4'd0, F_IDLE);
    hand("rv2_after",    I_ACK,  6'd0,  4'd0, F_IDLE);

    if (sb.size() != 0) begin
      total++; bad++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
